imem_loader: RTL and testbench

//  Byte-addressed Y86-64 instruction memory with a streaming program-load port.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 59 +++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: load, stream, fetch and status signals of imem_loader.
//   load_start_i/load_base_i/load_len_i : load request, latched on start
//   s_valid_i/s_data_i/s_ready_o        : byte stream into memory
//   f_pc_i/f_inst_o/f_adr_err_o         : 10-byte combinational fetch window
//   cpu_rstn_o/busy_o/done_o/load_cnt_o : core reset and loader status
interface imem_loader_if #(parameter int ADDR_W = 10);
  logic              load_start_i;
  logic [ADDR_W-1:0] load_base_i;
  logic [ADDR_W:0]   load_len_i;
  logic              s_valid_i;
  logic [7:0]        s_data_i;
  logic              s_ready_o;
  logic [63:0]       f_pc_i;
  logic [79:0]       f_inst_o;
  logic              f_adr_err_o;
  logic              cpu_rstn_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   load_cnt_o;
  modport slave (
    input  load_start_i, load_base_i, load_len_i, s_valid_i, s_data_i, f_pc_i,
    output s_ready_o, f_inst_o, f_adr_err_o, cpu_rstn_o, busy_o, done_o, load_cnt_o
  );
  modport master (
    output load_start_i, load_base_i, load_len_i, s_valid_i, s_data_i, f_pc_i,
    input  s_ready_o, f_inst_o, f_adr_err_o, cpu_rstn_o, busy_o, done_o, load_cnt_o
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-addressed Y86-64 instruction memory with streaming program load.
//   clk_i : single clock, rising edge
//   rst_i : synchronous active-high reset (memory contents are kept)
//   bus   : imem_loader_if.slave carrying load request, byte stream, fetch port, status
// The core is held in reset (cpu_rstn_o low) while a program streams in, then released.
module imem_loader #(parameter int ADDR_W = 10) (
  input logic          clk_i,
  input logic          rst_i,
  imem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
  state_t            state, stateNext;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len, cnt;
  logic [7:0]        mem [2**ADDR_W];
  logic              hs, startOk, hiErr;
  logic [ADDR_W-1:0] wrAddr, pcLo;
  assign hs      = (state == LOAD) && bus.s_valid_i;
  assign startOk = bus.load_start_i && (state == IDLE || state == RUN);
  assign wrAddr  = base + cnt[ADDR_W-1:0];
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, RUN: if (bus.load_start_i) stateNext = (bus.load_len_i == '0) ? RELEASE : LOAD;
      LOAD:      if (hs && cnt + (ADDR_W+1)'(1) == len) stateNext = RELEASE;
      RELEASE:   stateNext = RUN;
      default:   stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      if (startOk) begin
        base <= bus.load_base_i;
        len  <= bus.load_len_i;
        cnt  <= '0;
      end else if (hs) cnt <= cnt + (ADDR_W+1)'(1);
    end
  end
  always_ff @(posedge clk_i) if (hs) mem[wrAddr] <= bus.s_data_i;
  assign bus.s_ready_o  = (state == LOAD);
  assign bus.cpu_rstn_o = (state == RUN);
  assign bus.busy_o     = (state == LOAD) || (state == RELEASE);
  assign bus.done_o     = (state == RUN);
  assign bus.load_cnt_o = cnt;
  // Window end checked as two parts so pc+9 never overflows 64 bits.
  assign hiErr           = |bus.f_pc_i[63:ADDR_W];
  assign pcLo            = bus.f_pc_i[ADDR_W-1:0];
  assign bus.f_adr_err_o = hiErr || (pcLo > ADDR_W'(2**ADDR_W - 10));
  // One extra index bit flags bytes past the top of memory; those read as zero instead of wrapping.
  for (genvar k = 0; k < 10; k++) begin : g_byte
    logic [ADDR_W:0] idx;
    assign idx = {1'b0, pcLo} + (ADDR_W+1)'(k);
    assign bus.f_inst_o[8*k +: 8] = (hiErr || idx[ADDR_W]) ? 8'h00 : mem[idx[ADDR_W-1:0]];
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader against a byte-array memory model.
module tb_imem_loader;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  typedef struct {string name; int kind; logic [79:0] exp;} chk_t;
  typedef struct {int idx; bit last;} hs_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.ADDR_W(AW)) dut(.clk_i(clk), .rst_i(rst), .bus(bus));
  chk_t chkQ[$];
  hs_t hsQ[$];
  logic [7:0] txq[$];
  logic [7:0] model [DEPTH];
  int total = 0, bad = 0, cyc = 0, refCyc = 0;
  bit armed = 0;
  logic prevRstn = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [79:0] probe(int kind);
    case (kind)
      0: return bus.f_inst_o;
      1: return 80'(bus.f_adr_err_o);
      2: return 80'(bus.cpu_rstn_o);
      3: return 80'(bus.s_ready_o);
      4: return 80'(bus.busy_o);
      5: return 80'(bus.done_o);
      default: return 80'(bus.load_cnt_o);
    endcase
  endfunction
  always @(negedge clk) begin
    chk_t c;
    hs_t h;
    while (chkQ.size() > 0) begin
      c = chkQ.pop_front();
      total++;
      if (probe(c.kind) !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", c.name, probe(c.kind), c.exp);
      end
    end
    if (bus.s_valid_i === 1'b1 && bus.s_ready_o === 1'b1) begin
      total++;
      if (hsQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_hs: got handshake at cnt=%0d want none", bus.load_cnt_o);
      end else begin
        h = hsQ.pop_front();
        if (bus.load_cnt_o !== (AW+1)'(h.idx)) begin
          bad++;
          $display("FAIL hs_cnt: got %0d want %0d", bus.load_cnt_o, h.idx);
        end
        if (h.last) begin armed = 1; refCyc = cyc; end
      end
    end
    if (armed && cyc == refCyc + 1) begin
      total++;
      if (bus.cpu_rstn_o !== 1'b0) begin bad++; $display("FAIL rstn_hold: got %b want 0", bus.cpu_rstn_o); end
    end else if (armed && cyc == refCyc + 2) begin
      total++;
      armed = 0;
      if (bus.cpu_rstn_o !== 1'b1) begin bad++; $display("FAIL rstn_rise: got %b want 1", bus.cpu_rstn_o); end
    end else if (!armed && bus.cpu_rstn_o === 1'b1 && prevRstn === 1'b0) begin
      total++;
      bad++;
      $display("FAIL rstn_unexpected: got 1 want 0 at cycle %0d", cyc);
    end
    prevRstn = bus.cpu_rstn_o;
    if (bus.load_start_i === 1'b1 && bus.load_len_i == '0) begin armed = 1; refCyc = cyc; end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(string n, int k, logic [79:0] e);
    chk_t c;
    c.name = n; c.kind = k; c.exp = e;
    chkQ.push_back(c);
  endtask
  task automatic status(string tag, bit rdy, bit rstn, bit busy, bit done, int cnt);
    push({tag, "_s_ready"}, 3, 80'(rdy));
    push({tag, "_cpu_rstn"}, 2, 80'(rstn));
    push({tag, "_busy"}, 4, 80'(busy));
    push({tag, "_done"}, 5, 80'(done));
    push({tag, "_load_cnt"}, 6, 80'(cnt));
  endtask
  task automatic startLoad(int base, int len);
    bus.load_base_i = AW'(base);
    bus.load_len_i = (AW+1)'(len);
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
  endtask
  task automatic stream(int base, int n, int len, int mode);
    bit togg = 1'b0;
    for (int i = 0; i < n; i++) begin
      int tries = 0;
      bit acc = 1'b0;
      hs_t h;
      h.idx = i; h.last = (i == len - 1);
      hsQ.push_back(h);
      bus.s_data_i = txq[i];
      while (!acc && tries < 64) begin
        bus.s_valid_i = (mode == 0) ? 1'b1 : (mode == 1) ? togg : 1'($urandom);
        togg = ~togg;
        @(negedge clk);
        acc = bus.s_valid_i && bus.s_ready_o;
        tick();
        tries++;
      end
      bus.s_valid_i = 1'b0;
      if (acc) model[(base + i) % DEPTH] = txq[i];
      if (mode == 0) begin
        total++;
        if (tries != 1) begin bad++; $display("FAIL hs_gap: got %0d cycles want 1 for byte %0d", tries, i); end
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL hs_timeout: got no handshake want byte %0d", i);
        void'(hsQ.pop_back());
        break;
      end
    end
  endtask
  task automatic finishLoad(int len);
    status("release", 0, 0, 1, 0, len);
    tick();
    status("run", 0, 1, 0, 1, len);
    tick();
  endtask
  task automatic fetchChk(logic [63:0] pc);
    logic [79:0] e = '0;
    bus.f_pc_i = pc;
    for (int k = 0; k < 10; k++)
      if (pc < DEPTH && pc + 64'(k) < DEPTH) e[8*k +: 8] = model[int'(pc) + k];
    push("fetch_inst", 0, e);
    push("fetch_err", 1, 80'(pc > 64'(DEPTH - 10)));
    tick();
  endtask
  task automatic randTx(int n);
    txq.delete();
    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int b;
    bus.load_start_i = 1'b0; bus.load_base_i = '0; bus.load_len_i = '0;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.f_pc_i = '0;
    tick(); tick();
    status("reset", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    b = int'($urandom_range(0, DEPTH - 1));
    randTx(DEPTH);
    startLoad(b, DEPTH);
    status("fill_load", 1, 0, 1, 0, 0);
    stream(b, DEPTH, DEPTH, 2);
    finishLoad(DEPTH);
    for (int i = 0; i < 8; i++) fetchChk(64'($urandom_range(0, DEPTH - 1)));
    txq = '{8'h30, 8'hF2, 8'h0A, 8'h00};
    startLoad(0, 4);
    stream(0, 4, 4, 0);
    finishLoad(4);
    fetchChk(64'd0);
    b = int'($urandom_range(0, DEPTH - 1));
    randTx(6);
    startLoad(b, 6);
    startLoad((b + 100) % DEPTH, 7);
    status("start_ignored", 1, 0, 1, 0, 0);
    stream(b, 6, 6, 1);
    finishLoad(6);
    fetchChk(64'(b));
    txq = '{8'h11, 8'h22, 8'h33, 8'h44};
    startLoad(12'h3FE, 4);
    stream(12'h3FE, 4, 4, 2);
    finishLoad(4);
    fetchChk(64'd0);
    fetchChk(64'h3FE);
    fetchChk(64'h3F6);
    fetchChk(64'h3F7);
    fetchChk(64'h1_0000_0000);
    fetchChk(64'hFFFF_FFFF_FFFF_FFFF);
    b = int'($urandom_range(0, DEPTH - 1));
    randTx(5);
    startLoad(b, 5);
    stream(b, 2, 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    status("midrst", 0, 0, 0, 0, 0);
    bus.s_data_i = 8'hA5;
    bus.s_valid_i = 1'b1;
    tick(); tick();
    bus.s_valid_i = 1'b0;
    status("idle_hold", 0, 0, 0, 0, 0);
    fetchChk(64'(b));
    startLoad(0, 0);
    finishLoad(0);
    b = int'($urandom_range(0, DEPTH - 1));
    randTx(3);
    startLoad(b, 3);
    status("restart", 1, 0, 1, 0, 0);
    stream(b, 3, 3, 2);
    finishLoad(3);
    fetchChk(64'(b));
    tick(); tick(); tick();
    if (hsQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL hs_left: got %0d pending want 0", hsQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
